// File: rtl/cache_def.sv
// Shared cache/memory types for the memory arbiter: widths, FSM states, requester ids.
// Round-robin arbitration is selected by defining MEM_ARB_RR_EN.
package cache_def;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~32'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } cache_req_t;

  typedef struct packed {
    logic              ready;
    logic [LINE_W-1:0] data;
  } cache_result_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a & LINE_MASK;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant choice between the instruction and data cache requesters.
// MEM_ARB_RR_EN: on contention grant whoever was not granted last; otherwise dc wins.
module arb_pick
  import cache_def::*;
(
  input  logic    ic_valid_i,
  input  logic    dc_valid_i,
`ifdef MEM_ARB_RR_EN
  input  req_id_e last_i,
`endif
  output logic    gnt_o,
  output req_id_e gnt_id_o
);

  always_comb begin
    gnt_o    = ic_valid_i | dc_valid_i;
    gnt_id_o = dc_valid_i ? REQ_DC : REQ_IC;
`ifdef MEM_ARB_RR_EN
    if (ic_valid_i && dc_valid_i) begin
      gnt_id_o = (last_i == REQ_DC) ? REQ_IC : REQ_DC;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter in front of a single main-memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed dc-over-ic priority.
module mem_arbiter
  import cache_def::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  output logic              ic_result_ready_o,
  output logic [LINE_W-1:0] ic_result_data_o,
  input  logic              dc_req_valid_i,
  input  logic              dc_req_rw_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic [LINE_W-1:0] dc_req_data_i,
  output logic              dc_result_ready_o,
  output logic [LINE_W-1:0] dc_result_data_o,
  output logic              mem_req_valid_o,
  output logic              mem_req_rw_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [LINE_W-1:0] mem_req_data_o,
  input  logic              mem_result_ready_i,
  input  logic [LINE_W-1:0] mem_result_data_i,
  output logic              err_timeout_o
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  arb_state_e        state_q;
  logic [15:0]       wait_cnt_q;
  logic              mem_req_valid_q;
  logic              mem_req_rw_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic [LINE_W-1:0] mem_req_data_q;
  logic              ic_ready_q;
  logic              dc_ready_q;
  logic [LINE_W-1:0] ic_data_q;
  logic [LINE_W-1:0] dc_data_q;
  logic              err_q;

  logic              gnt;
  req_id_e           gnt_id;
  logic              settle;
  cache_req_t        req_d;

`ifdef MEM_ARB_RR_EN
  req_id_e           last_q;

  arb_pick u_pick (
    .ic_valid_i (ic_req_valid_i),
    .dc_valid_i (dc_req_valid_i),
    .last_i     (last_q),
    .gnt_o      (gnt),
    .gnt_id_o   (gnt_id)
  );
`else
  arb_pick u_pick (
    .ic_valid_i (ic_req_valid_i),
    .dc_valid_i (dc_req_valid_i),
    .gnt_o      (gnt),
    .gnt_id_o   (gnt_id)
  );
`endif

  // The cycle carrying a result/abort pulse is a settle cycle: the retiring
  // requester still shows valid, so no grant is allowed until the next cycle.
  assign settle = ic_ready_q | dc_ready_q | err_q;

  always_comb begin
    req_d       = '0;
    req_d.valid = gnt & ~settle;
    if (gnt_id == REQ_DC) begin
      req_d.rw   = dc_req_rw_i;
      req_d.addr = line_addr(dc_req_addr_i);
      req_d.data = dc_req_data_i;
    end else begin
      req_d.addr = line_addr(ic_req_addr_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wait_cnt_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
      ic_ready_q      <= 1'b0;
      dc_ready_q      <= 1'b0;
      ic_data_q       <= '0;
      dc_data_q       <= '0;
      err_q           <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q          <= REQ_IC;
`endif
    end else begin
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_d.valid) begin
            mem_req_valid_q <= 1'b1;
            mem_req_rw_q    <= req_d.rw;
            mem_req_addr_q  <= req_d.addr;
            mem_req_data_q  <= req_d.data;
            wait_cnt_q      <= '0;
            state_q         <= (gnt_id == REQ_DC) ? GRANT_D : GRANT_I;
`ifdef MEM_ARB_RR_EN
            last_q          <= gnt_id;
`endif
          end
        end
        GRANT_I, GRANT_D: begin
          // A completion in the same cycle the counter expires still wins.
          if (mem_result_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= IDLE;
            if (state_q == GRANT_I) begin
              ic_ready_q <= 1'b1;
              ic_data_q  <= mem_result_data_i;
            end else begin
              dc_ready_q <= 1'b1;
              dc_data_q  <= mem_result_data_i;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
            if (wait_cnt_q + 16'd1 == TIMEOUT_C) begin
              mem_req_valid_q <= 1'b0;
              err_q           <= 1'b1;
              state_q         <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ic_result_ready_o = ic_ready_q;
  assign ic_result_data_o  = ic_data_q;
  assign dc_result_ready_o = dc_ready_q;
  assign dc_result_data_o  = dc_data_q;
  assign mem_req_valid_o   = mem_req_valid_q;
  assign mem_req_rw_o      = mem_req_rw_q;
  assign mem_req_addr_o    = mem_req_addr_q;
  assign mem_req_data_o    = mem_req_data_q;
  assign err_timeout_o     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory requests and results are queued
// as stimulus is driven and compared when the DUT presents them.
module tb_mem_arbiter;
  import cache_def::*;

  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ic_req_valid_i = 1'b0;
  logic [ADDR_W-1:0] ic_req_addr_i = '0;
  logic              ic_result_ready_o;
  logic [LINE_W-1:0] ic_result_data_o;
  logic              dc_req_valid_i = 1'b0;
  logic              dc_req_rw_i = 1'b0;
  logic [ADDR_W-1:0] dc_req_addr_i = '0;
  logic [LINE_W-1:0] dc_req_data_i = '0;
  logic              dc_result_ready_o;
  logic [LINE_W-1:0] dc_result_data_o;
  logic              mem_req_valid_o;
  logic              mem_req_rw_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic [LINE_W-1:0] mem_req_data_o;
  logic              mem_result_ready_i = 1'b0;
  logic [LINE_W-1:0] mem_result_data_i = '0;
  logic              err_timeout_o;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ic_req_valid_i     (ic_req_valid_i),
    .ic_req_addr_i      (ic_req_addr_i),
    .ic_result_ready_o  (ic_result_ready_o),
    .ic_result_data_o   (ic_result_data_o),
    .dc_req_valid_i     (dc_req_valid_i),
    .dc_req_rw_i        (dc_req_rw_i),
    .dc_req_addr_i      (dc_req_addr_i),
    .dc_req_data_i      (dc_req_data_i),
    .dc_result_ready_o  (dc_result_ready_o),
    .dc_result_data_o   (dc_result_data_o),
    .mem_req_valid_o    (mem_req_valid_o),
    .mem_req_rw_o       (mem_req_rw_o),
    .mem_req_addr_o     (mem_req_addr_o),
    .mem_req_data_o     (mem_req_data_o),
    .mem_result_ready_i (mem_result_ready_i),
    .mem_result_data_i  (mem_result_data_i),
    .err_timeout_o      (err_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } mreq_t;

  typedef struct packed {
    logic              chk;
    logic [LINE_W-1:0] data;
  } res_t;

  int n_checks = 0;
  int n_errors = 0;
  mreq_t             exp_req_q[$];
  logic [LINE_W-1:0] exp_ic_q[$];
  res_t              exp_dc_q[$];

  bit                mem_auto = 1'b0;
  bit                mem_addr_data = 1'b0;
  int                mem_lat = 0;
  int                mem_cnt = 0;
  logic [LINE_W-1:0] mem_rdata = '0;
  mreq_t             cur_req;
  bit                err_allowed = 1'b0;

  // Memory model: checks each new request against the scoreboard, then answers after mem_lat cycles.
  always @(negedge clk) begin
    if (mem_req_valid_o === 1'b1) begin
      mem_cnt = mem_cnt + 1;
      if (mem_cnt == 1) begin
        cur_req = '{mem_req_rw_o, mem_req_addr_o, mem_req_data_o};
        n_checks++;
        if (exp_req_q.size() == 0) begin
          n_errors++;
          $display("FAIL mem_req_unexpected: got rw=%0b addr=%h, none expected", mem_req_rw_o, mem_req_addr_o);
        end else begin
          mreq_t e;
          e = exp_req_q.pop_front();
          if (cur_req !== e) begin
            n_errors++;
            $display("FAIL mem_req: got rw=%0b addr=%h data=%h, want rw=%0b addr=%h data=%h",
                     cur_req.rw, cur_req.addr, cur_req.data, e.rw, e.addr, e.data);
          end
        end
      end else begin
        n_checks++;
        if ({mem_req_rw_o, mem_req_addr_o, mem_req_data_o} !== cur_req) begin
          n_errors++;
          $display("FAIL mem_req_hold: got addr=%h, want addr=%h held", mem_req_addr_o, cur_req.addr);
        end
      end
      if (mem_auto) begin
        mem_result_ready_i = (mem_lat != 0) && (mem_cnt == mem_lat);
        mem_result_data_i  = mem_addr_data ? {4{mem_req_addr_o}} : mem_rdata;
      end
    end else begin
      mem_cnt = 0;
      if (mem_auto) mem_result_ready_i = 1'b0;
    end
  end

  // Result monitor: every pulse must match the head of its requester's queue.
  always @(negedge clk) begin
    if (ic_result_ready_o === 1'b1) begin
      n_checks++;
      if (exp_ic_q.size() == 0) begin
        n_errors++;
        $display("FAIL ic_result_unexpected: got pulse data=%h, want no pulse", ic_result_data_o);
      end else begin
        logic [LINE_W-1:0] e;
        e = exp_ic_q.pop_front();
        if (ic_result_data_o !== e) begin
          n_errors++;
          $display("FAIL ic_result_data: got %h, want %h", ic_result_data_o, e);
        end
      end
    end
    if (dc_result_ready_o === 1'b1) begin
      n_checks++;
      if (exp_dc_q.size() == 0) begin
        n_errors++;
        $display("FAIL dc_result_unexpected: got pulse data=%h, want no pulse", dc_result_data_o);
      end else begin
        res_t e;
        e = exp_dc_q.pop_front();
        if (e.chk && dc_result_data_o !== e.data) begin
          n_errors++;
          $display("FAIL dc_result_data: got %h, want %h", dc_result_data_o, e.data);
        end
      end
    end
    if (err_timeout_o === 1'b1 && !err_allowed) begin
      n_checks++;
      n_errors++;
      $display("FAIL err_unexpected: got err_timeout=1, want 0");
    end
  end

  // Requester driver: retire ic_n / dc_n transfers; a held requester moves to the next line.
  task automatic drive_until(input int ic_n, input int dc_n, input int budget);
    int ic_done = 0;
    int dc_done = 0;
    int cyc = 0;
    while ((ic_done < ic_n || dc_done < dc_n) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (ic_result_ready_o === 1'b1 && ic_done < ic_n) begin
        ic_done++;
        if (ic_done == ic_n) ic_req_valid_i = 1'b0;
        else ic_req_addr_i = ic_req_addr_i + 32'h100;
      end
      if (dc_result_ready_o === 1'b1 && dc_done < dc_n) begin
        dc_done++;
        if (dc_done == dc_n) dc_req_valid_i = 1'b0;
        else dc_req_addr_i = dc_req_addr_i + 32'h100;
      end
    end
    n_checks++;
    if (ic_done != ic_n || dc_done != dc_n) begin
      n_errors++;
      $display("FAIL retire_budget: got ic=%0d dc=%0d, want ic=%0d dc=%0d", ic_done, dc_done, ic_n, dc_n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_req_valid_o, ic_result_ready_o, dc_result_ready_o, err_timeout_o} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b, want 0000",
               {mem_req_valid_o, ic_result_ready_o, dc_result_ready_o, err_timeout_o});
    end
    n_checks++;
    if ({mem_req_addr_o, mem_req_data_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_mem_req: got addr=%h data=%h, want 0", mem_req_addr_o, mem_req_data_o);
    end
    n_checks++;
    if ({ic_result_data_o, dc_result_data_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_result_data: got ic=%h dc=%h, want 0", ic_result_data_o, dc_result_data_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ic_read();
    mem_auto = 1'b1; mem_addr_data = 1'b0; mem_lat = 3; mem_rdata = {16{8'hA5}};
    exp_req_q.push_back('{1'b0, 32'h0000_1230, '0});
    exp_ic_q.push_back({16{8'hA5}});
    ic_req_addr_i = 32'h0000_1234; ic_req_valid_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_req_valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL ic_grant_latency: got mem_req_valid=%b, want 1", mem_req_valid_o);
    end
    drive_until(1, 0, 20);
    @(negedge clk);
    n_checks++;
    if (ic_result_ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL ic_pulse_width: got ready=%b one cycle after pulse, want 0", ic_result_ready_o);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (ic_result_data_o !== {16{8'hA5}}) begin
      n_errors++;
      $display("FAIL ic_data_hold: got %h, want a5 repeated", ic_result_data_o);
    end
  endtask

  task automatic test_dc_write();
    mem_addr_data = 1'b1; mem_lat = 2;
    exp_req_q.push_back('{1'b1, 32'h8000_0040, {4{32'h1111_1111}}});
    exp_dc_q.push_back('{1'b0, '0});
    dc_req_rw_i = 1'b1; dc_req_addr_i = 32'h8000_0040; dc_req_data_i = {4{32'h1111_1111}};
    dc_req_valid_i = 1'b1;
    drive_until(0, 1, 20);
    dc_req_rw_i = 1'b0; dc_req_data_i = '0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    mem_lat = 2;
`ifdef MEM_ARB_RR_EN
    exp_req_q.push_back('{1'b0, 32'h0000_2000, '0});
    exp_req_q.push_back('{1'b0, 32'h0000_3000, '0});
`else
    exp_req_q.push_back('{1'b0, 32'h0000_3000, '0});
    exp_req_q.push_back('{1'b0, 32'h0000_2000, '0});
`endif
    exp_ic_q.push_back({4{32'h0000_2000}});
    exp_dc_q.push_back('{1'b1, {4{32'h0000_3000}}});
    ic_req_addr_i = 32'h0000_2008; dc_req_addr_i = 32'h0000_300C;
    ic_req_valid_i = 1'b1; dc_req_valid_i = 1'b1;
    drive_until(1, 1, 40);
    @(negedge clk);
  endtask

  task automatic test_drop_mid();
    mem_lat = 3;
    exp_req_q.push_back('{1'b0, 32'h0000_4000, '0});
    exp_dc_q.push_back('{1'b1, {4{32'h0000_4000}}});
    dc_req_addr_i = 32'h0000_4004; dc_req_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    dc_req_valid_i = 1'b0;
    drive_until(0, 1, 20);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int vcnt = 0;
    int cyc = 0;
    bit seen = 1'b0;
    mem_lat = 0;
    exp_req_q.push_back('{1'b0, 32'h0000_5000, '0});
    exp_req_q.push_back('{1'b0, 32'h0000_6000, '0});
    exp_ic_q.push_back({4{32'h0000_6000}});
    err_allowed = 1'b1;
    dc_req_addr_i = 32'h0000_5008; dc_req_valid_i = 1'b1;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        ic_req_addr_i = 32'h0000_6004; ic_req_valid_i = 1'b1;
      end
      if (err_timeout_o === 1'b1) begin
        seen = 1'b1;
        n_checks++;
        if (vcnt != TO) begin
          n_errors++;
          $display("FAIL timeout_cycles: got %0d waiting cycles, want %0d", vcnt, TO);
        end
        n_checks++;
        if (mem_req_valid_o !== 1'b0) begin
          n_errors++;
          $display("FAIL timeout_drop: got mem_req_valid=%b at abort, want 0", mem_req_valid_o);
        end
        dc_req_valid_i = 1'b0;
        mem_lat = 2;
      end else if (mem_req_valid_o === 1'b1) begin
        vcnt++;
      end
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL timeout_seen: got no err_timeout within 20 cycles, want one pulse");
    end
    @(negedge clk);
    n_checks++;
    if (err_timeout_o !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_pulse_width: got err=%b, want 0", err_timeout_o);
    end
    err_allowed = 1'b0;
    drive_until(1, 0, 20);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem_lat = 0;
    exp_req_q.push_back('{1'b0, 32'h0000_7000, '0});
    dc_req_addr_i = 32'h0000_7000; dc_req_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req_valid_o, mem_req_rw_o, ic_result_ready_o, dc_result_ready_o, err_timeout_o} !== 5'b0 ||
        {mem_req_addr_o, mem_req_data_o, ic_result_data_o, dc_result_data_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_async: got valid=%b addr=%h icd=%h, want all 0",
               mem_req_valid_o, mem_req_addr_o, ic_result_data_o);
    end
    dc_req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_auto = 1'b0;
    mem_result_ready_i = 1'b1; mem_result_data_i = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    mem_result_ready_i = 1'b0;
    n_checks++;
    if ({ic_result_ready_o, dc_result_ready_o, mem_req_valid_o} !== 3'b0) begin
      n_errors++;
      $display("FAIL stray_ready: got ic=%b dc=%b valid=%b, want 000",
               ic_result_ready_o, dc_result_ready_o, mem_req_valid_o);
    end
    @(negedge clk);
    mem_auto = 1'b1;
  endtask

  task automatic test_back_to_back();
    mem_lat = 1;
    exp_req_q.push_back('{1'b0, 32'h0000_8000, '0});
`ifdef MEM_ARB_RR_EN
    exp_req_q.push_back('{1'b0, 32'h0000_9000, '0});
    exp_req_q.push_back('{1'b0, 32'h0000_8100, '0});
`else
    exp_req_q.push_back('{1'b0, 32'h0000_8100, '0});
    exp_req_q.push_back('{1'b0, 32'h0000_9000, '0});
`endif
    exp_dc_q.push_back('{1'b1, {4{32'h0000_8000}}});
    exp_dc_q.push_back('{1'b1, {4{32'h0000_8100}}});
    exp_ic_q.push_back({4{32'h0000_9000}});
    dc_req_addr_i = 32'h0000_8000; ic_req_addr_i = 32'h0000_9000;
    dc_req_valid_i = 1'b1; ic_req_valid_i = 1'b1;
    drive_until(1, 2, 60);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_write();
    test_contention();
    test_drop_mid();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_req_q.size() != 0 || exp_ic_q.size() != 0 || exp_dc_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got req=%0d ic=%0d dc=%0d left, want 0",
               exp_req_q.size(), exp_ic_q.size(), exp_dc_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want finish");
    $fatal(1, "watchdog");
  end

endmodule
